// File: rtl/dma_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_copy_pkg
// Purpose  : Shared definitions for the dma_copy engine: register word
//            offsets (device address bits [4:2]), CTRL/STATUS bit indices
//            and the transfer state encoding.
// Config   : DMA_COPY_IRQ_EN (consumed by dma_copy_regs)
// Revision : 1.0 - initial release
// ============================================================================
package dma_copy_pkg;

   // Register word offsets (byte address >> 2)
   localparam logic [2:0] REG_SRC    = 3'd0;
   localparam logic [2:0] REG_DST    = 3'd1;
   localparam logic [2:0] REG_LEN    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_STATUS = 3'd4;

   // CTRL bits
   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;

   // STATUS bits
   localparam int STATUS_BUSY = 0;
   localparam int STATUS_DONE = 1;
   localparam int STATUS_ERR  = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_WAIT = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_WAIT = 3'd4,
      ST_FIN     = 3'd5
   } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_copy_regs.sv
`default_nettype none
// ============================================================================
// Module   : dma_copy_regs
// Purpose  : Programming registers of the copy engine and the device-port
//            response path (1-cycle registered read data).
// Ports    : device_*     - register access port from the core
//            busy         - transfer in progress (from FSM)
//            done_set     - one-cycle pulse: transfer finished
//            err_set      - one-cycle pulse: bus error seen
//            start        - one-cycle start pulse to the FSM
//            src/dst/len  - programmed transfer configuration
//            irq          - level completion interrupt
// Config   : DMA_COPY_IRQ_EN - when defined, CTRL.IRQ_EN exists and
//            irq = DONE & IRQ_EN; otherwise irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module dma_copy_regs
   import dma_copy_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int LenWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 device_req_i,
   input  logic [AddrWidth-1:0] device_addr_i,
   input  logic                 device_we_i,
   input  logic [3:0]           device_be_i,
   input  logic [DataWidth-1:0] device_wdata_i,
   output logic                 device_rvalid_o,
   output logic [DataWidth-1:0] device_rdata_o,
   input  logic                 busy,
   input  logic                 done_set,
   input  logic                 err_set,
   output logic                 start,
   output logic [AddrWidth-1:0] src,
   output logic [AddrWidth-1:0] dst,
   output logic [LenWidth-1:0]  len,
   output logic                 irq
);

   logic                 wr;
   logic                 rd;
   logic [2:0]           sel;
   logic                 done;
   logic                 err;
   logic                 irq_en;
   logic [DataWidth-1:0] rd_data;

   assign sel = device_addr_i[4:2];
   assign wr  = device_req_i &  device_we_i;
   assign rd  = device_req_i & ~device_we_i;

   // Byte enables and undecoded address bits are intentionally ignored.
   logic unused_bits;
   assign unused_bits = ^{device_be_i, device_addr_i[AddrWidth-1:5], device_addr_i[1:0]};

   assign start = wr & (sel == REG_CTRL) & device_wdata_i[CTRL_START] & ~busy;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src  <= '0;
         dst  <= '0;
         len  <= '0;
         done <= 1'b0;
         err  <= 1'b0;
      end else begin
         if (wr) begin
            done <= 1'b0;
            err  <= 1'b0;
            if (!busy) begin
               case (sel)
                  REG_SRC: src <= {device_wdata_i[AddrWidth-1:2], 2'b00};
                  REG_DST: dst <= {device_wdata_i[AddrWidth-1:2], 2'b00};
                  REG_LEN: len <= device_wdata_i[LenWidth-1:0];
                  default: ;
               endcase
            end
         end
         // A completion event in the same cycle as a write is newer, so it wins.
         if (done_set) done <= 1'b1;
         if (err_set)  err  <= 1'b1;
      end
   end

`ifdef DMA_COPY_IRQ_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en <= 1'b0;
      end else if (wr && (sel == REG_CTRL)) begin
         irq_en <= device_wdata_i[CTRL_IRQ_EN];
      end
   end
   assign irq = done & irq_en;
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (sel)
         REG_SRC:    rd_data = DataWidth'(src);
         REG_DST:    rd_data = DataWidth'(dst);
         REG_LEN:    rd_data = DataWidth'(len);
         REG_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en;
         REG_STATUS: begin
            rd_data[STATUS_BUSY] = busy;
            rd_data[STATUS_DONE] = done;
            rd_data[STATUS_ERR]  = err;
         end
         default:    rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         device_rvalid_o <= 1'b0;
         device_rdata_o  <= '0;
      end else begin
         device_rvalid_o <= device_req_i;
         device_rdata_o  <= rd ? rd_data : '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dma_copy.sv
`default_nettype none
// ============================================================================
// Module   : dma_copy
// Purpose  : Word-granular memory-to-memory copy engine. The core programs
//            SRC/DST/LEN through the device port; the engine then reads one
//            word from SRC and writes it to DST, one bus transaction at a time.
// Ports    : clk_i/rst_ni  - clock, async active-low reset
//            device_*      - register access port (slave)
//            host_*        - bus master port, one outstanding transaction
//            irq_o         - completion interrupt
// Config   : DMA_COPY_IRQ_EN - enables CTRL.IRQ_EN and irq_o (see regs)
// Revision : 1.0 - initial release
// ============================================================================
module dma_copy
   import dma_copy_pkg::*;
#(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32,
   parameter int LenWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 device_req_i,
   input  logic [AddrWidth-1:0] device_addr_i,
   input  logic                 device_we_i,
   input  logic [3:0]           device_be_i,
   input  logic [DataWidth-1:0] device_wdata_i,
   output logic                 device_rvalid_o,
   output logic [DataWidth-1:0] device_rdata_o,
   output logic                 host_req_o,
   input  logic                 host_gnt_i,
   output logic [AddrWidth-1:0] host_addr_o,
   output logic                 host_we_o,
   output logic [3:0]           host_be_o,
   output logic [DataWidth-1:0] host_wdata_o,
   input  logic                 host_rvalid_i,
   input  logic [DataWidth-1:0] host_rdata_i,
   input  logic                 host_err_i,
   output logic                 irq_o
);

   dma_state_e           state;
   dma_state_e           state_next;
   logic [AddrWidth-1:0] cur_src;
   logic [AddrWidth-1:0] cur_dst;
   logic [LenWidth-1:0]  remaining;
   logic [DataWidth-1:0] buffer;

   logic                 start;
   logic                 busy;
   logic                 done_set;
   logic                 err_set;
   logic [AddrWidth-1:0] src;
   logic [AddrWidth-1:0] dst;
   logic [LenWidth-1:0]  len;

   dma_copy_regs #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .LenWidth  (LenWidth)
   ) u_regs (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .device_req_i    (device_req_i),
      .device_addr_i   (device_addr_i),
      .device_we_i     (device_we_i),
      .device_be_i     (device_be_i),
      .device_wdata_i  (device_wdata_i),
      .device_rvalid_o (device_rvalid_o),
      .device_rdata_o  (device_rdata_o),
      .busy            (busy),
      .done_set        (done_set),
      .err_set         (err_set),
      .start           (start),
      .src             (src),
      .dst             (dst),
      .len             (len),
      .irq             (irq_o)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= ST_IDLE;
      else         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (start) state_next = (len == '0) ? ST_FIN : ST_RD_REQ;
         ST_RD_REQ:  if (host_gnt_i) state_next = ST_RD_WAIT;
         ST_RD_WAIT: if (host_rvalid_i) state_next = host_err_i ? ST_FIN : ST_WR_REQ;
         ST_WR_REQ:  if (host_gnt_i) state_next = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (host_rvalid_i) begin
               if (host_err_i || (remaining == LenWidth'(1))) state_next = ST_FIN;
               else                                           state_next = ST_RD_REQ;
            end
         end
         ST_FIN:     state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Working copies: the programmed registers stay untouched during a transfer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
         buffer    <= '0;
      end else begin
         if ((state == ST_IDLE) && start) begin
            cur_src   <= src;
            cur_dst   <= dst;
            remaining <= len;
         end
         if ((state == ST_RD_WAIT) && host_rvalid_i && !host_err_i) begin
            buffer <= host_rdata_i;
         end
         // Pointers only advance on a write that completed without error.
         if ((state == ST_WR_WAIT) && host_rvalid_i && !host_err_i) begin
            cur_src   <= cur_src + AddrWidth'(4);
            cur_dst   <= cur_dst + AddrWidth'(4);
            remaining <= remaining - LenWidth'(1);
         end
      end
   end

   assign host_be_o = 4'hF;

   // Output logic; address/data are driven straight from registers so they
   // stay stable while a request waits for grant.
   always_comb begin
      host_req_o   = 1'b0;
      host_we_o    = 1'b0;
      host_addr_o  = '0;
      host_wdata_o = '0;
      busy         = 1'b0;
      done_set     = 1'b0;
      err_set      = 1'b0;
      case (state)
         ST_RD_REQ: begin
            busy        = 1'b1;
            host_req_o  = 1'b1;
            host_addr_o = cur_src;
         end
         ST_RD_WAIT: begin
            busy    = 1'b1;
            err_set = host_rvalid_i & host_err_i;
         end
         ST_WR_REQ: begin
            busy         = 1'b1;
            host_req_o   = 1'b1;
            host_we_o    = 1'b1;
            host_addr_o  = cur_dst;
            host_wdata_o = buffer;
         end
         ST_WR_WAIT: begin
            busy    = 1'b1;
            err_set = host_rvalid_i & host_err_i;
         end
         ST_FIN:  done_set = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire
